// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: branch counter encodings, PC increment and RV32 control-flow decode values.
// Combinational helpers only.
package fetch_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam int unsigned PC_INC = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_JALR = 3'b000;

  // Saturating 2-bit direction counter step.
  function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters; combinational read, write on clock edge.
// A same-cycle read of the written index sees the old entry; no backpressure, writes always accepted.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-3:0] rd_addr,
  output logic            rd_hit,
  output ctr_t            rd_ctr,
  output logic [XLEN-1:0] rd_target,
  input  logic            wr_en,
  input  logic [XLEN-3:0] wr_addr,
  input  logic            wr_taken,
  input  logic [XLEN-1:0] wr_target
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = XLEN - 2 - IDX_W;

  logic [DEPTH-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];
  ctr_t             ctr_q [DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic             wr_hit;

  assign rd_idx = rd_addr[IDX_W-1:0];
  assign rd_tag = rd_addr[XLEN-3:IDX_W];
  assign wr_idx = wr_addr[IDX_W-1:0];
  assign wr_tag = wr_addr[XLEN-3:IDX_W];

  assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_ctr    = ctr_q[rd_idx];
  assign rd_target = tgt_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  // Only valid bits are reset; tag/target/counter are qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        if (wr_taken) begin
          tgt_q[wr_idx] <= wr_target;
        end
      end else if (wr_taken) begin
        valid_q[wr_idx] <= 1'b1;
        tag_q[wr_idx]   <= wr_tag;
        tgt_q[wr_idx]   <= wr_target;
        ctr_q[wr_idx]   <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC register with BTB prediction and execute-stage mispredict redirect; pc is registered, flush is combinational.
// stall holds the PC but never blocks a redirect or a BTB update.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BTB_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic            ex_is_jalr,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_base,
  input  logic [XLEN-1:0] ex_imm,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  output logic            flush
);

  localparam logic [XLEN-1:0] INC = XLEN'(PC_INC);

  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] ex_seq;
  logic [XLEN-1:0] actual_next;
  logic            ex_live;

  logic            btb_hit;
  ctr_t            btb_ctr;
  logic [XLEN-1:0] btb_target;

  // Plain modular add: negative immediates wrap naturally.
  assign target_sum  = ex_base + ex_imm;
  assign target      = ex_is_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
  assign ex_seq      = ex_pc + INC;
  assign actual_next = ex_taken ? target : ex_seq;
  assign ex_live     = ex_valid && !rst;

  assign flush = ex_live &&
                 ((ex_taken != ex_pred_taken) ||
                  (ex_taken && (target != ex_pred_target)));

  assign pred_taken  = btb_hit && btb_ctr[1];
  assign pred_target = pred_taken ? btb_target : (pc + INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= actual_next;
    end else if (!stall) begin
      pc <= pred_target;
    end
  end

  fetch_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (pc[XLEN-1:2]),
    .rd_hit    (btb_hit),
    .rd_ctr    (btb_ctr),
    .rd_target (btb_target),
    .wr_en     (ex_live),
    .wr_addr   (ex_pc[XLEN-1:2]),
    .wr_taken  (ex_taken),
    .wr_target (target)
  );

endmodule
